// File: rtl/wb_pkg.sv
// Shared Wishbone widths, arbiter state encoding, request payload and round-robin helpers.
package wb_pkg;

  localparam int unsigned ADR_W     = 32;
  localparam int unsigned DAT_W     = 32;
  localparam int unsigned SEL_W     = 4;
  localparam int unsigned MAX_M     = 8;
  localparam int unsigned MAX_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    TIMEOUT = 2'd2
  } state_e;

  typedef struct packed {
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [SEL_W-1:0] sel;
    logic [DAT_W-1:0] dat;
  } wb_req_t;

  // First requester strictly after `last`, wrapping modulo n; 0 when nobody requests.
  function automatic logic [MAX_IDX_W-1:0] rr_next(input logic [MAX_M-1:0]     req,
                                                   input logic [MAX_IDX_W-1:0] last,
                                                   input int unsigned          n);
    logic [MAX_IDX_W-1:0] sel;
    logic                 found;
    int unsigned          idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_M; k++) begin
      idx = (32'(last) + k) % n;
      if (!found && (k <= n) && req[MAX_IDX_W'(idx)]) begin
        sel   = MAX_IDX_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_M-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_M; i++) begin
      if (oh[i]) idx = MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: one-hot grant to the first requester after `last`.
module rr_select
  import wb_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt
);

  logic [MAX_IDX_W-1:0] w_idx;

  always_comb begin
    w_idx = rr_next(MAX_M'(req), MAX_IDX_W'(last), N);
    gnt   = (|req) ? N'(N'(1) << w_idx) : '0;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone classic arbiter with cycle-long grant lock and a stalled-strobe watchdog.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_MASTERS-1:0]       m_cyc_i,
  input  logic [NUM_MASTERS-1:0]       m_stb_i,
  input  logic [NUM_MASTERS-1:0]       m_we_i,
  input  logic [ADR_W*NUM_MASTERS-1:0] m_adr_i,
  input  logic [SEL_W*NUM_MASTERS-1:0] m_sel_i,
  input  logic [DAT_W*NUM_MASTERS-1:0] m_dat_i,
  output logic [DAT_W-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]       m_ack_o,
  output logic [NUM_MASTERS-1:0]       m_err_o,
  output logic [NUM_MASTERS-1:0]       m_rty_o,
  output logic                         s_cyc_o,
  output logic                         s_stb_o,
  output logic                         s_we_o,
  output logic [ADR_W-1:0]             s_adr_o,
  output logic [SEL_W-1:0]             s_sel_o,
  output logic [DAT_W-1:0]             s_dat_o,
  input  logic [DAT_W-1:0]             s_dat_i,
  input  logic                         s_ack_i,
  input  logic                         s_err_i,
  input  logic                         s_rty_i,
  output logic [NUM_MASTERS-1:0]       grant_o
);

  localparam int unsigned IDX_W   = $clog2(NUM_MASTERS);
  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          WDOG_EN = (TIMEOUT_CYCLES != 0);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [IDX_W-1:0]       r_last;
  logic [CNT_W-1:0]       r_wdog;
  logic [NUM_MASTERS-1:0] w_rr_gnt;
  logic [IDX_W-1:0]       w_rr_idx;
  wb_req_t                w_req;
  logic                   w_cyc_g;
  logic                   w_stb_g;
  logic                   w_term;
  logic                   w_stall;
  logic                   w_fire;

  rr_select #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req  (m_cyc_i),
    .last (r_last),
    .gnt  (w_rr_gnt)
  );

  assign w_rr_idx = IDX_W'(onehot_to_idx(MAX_M'(w_rr_gnt)));

  // While a grant is held r_last is the granted master's index.
  always_comb begin
    w_cyc_g    = m_cyc_i[r_last];
    w_stb_g    = m_stb_i[r_last];
    w_req.we   = m_we_i[r_last];
    w_req.adr  = m_adr_i[32'(r_last)*ADR_W +: ADR_W];
    w_req.sel  = m_sel_i[32'(r_last)*SEL_W +: SEL_W];
    w_req.dat  = m_dat_i[32'(r_last)*DAT_W +: DAT_W];
  end

  assign w_term  = s_ack_i | s_err_i | s_rty_i;
  assign w_stall = (r_state == GRANTED) && w_stb_g && !w_term;
  assign w_fire  = WDOG_EN && w_stall && (r_wdog == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    s_cyc_o     = 1'b0;
    s_stb_o     = 1'b0;
    s_we_o      = 1'b0;
    s_adr_o     = '0;
    s_sel_o     = '0;
    s_dat_o     = '0;
    m_ack_o     = '0;
    m_err_o     = '0;
    m_rty_o     = '0;
    case (r_state)
      IDLE: begin
        if (|m_cyc_i) w_state_nxt = GRANTED;
      end
      GRANTED: begin
        s_cyc_o = w_cyc_g;
        s_stb_o = w_stb_g;
        s_we_o  = w_req.we;
        s_adr_o = w_req.adr;
        s_sel_o = w_req.sel;
        s_dat_o = w_req.dat;
        m_ack_o = NUM_MASTERS'(NUM_MASTERS'(s_ack_i) << r_last);
        m_err_o = NUM_MASTERS'(NUM_MASTERS'(s_err_i) << r_last);
        m_rty_o = NUM_MASTERS'(NUM_MASTERS'(s_rty_i) << r_last);
        if (!w_cyc_g)    w_state_nxt = IDLE;
        else if (w_fire) w_state_nxt = TIMEOUT;
      end
      TIMEOUT: begin
        s_we_o      = w_req.we;
        s_adr_o     = w_req.adr;
        s_sel_o     = w_req.sel;
        s_dat_o     = w_req.dat;
        m_err_o     = NUM_MASTERS'(NUM_MASTERS'(1) << r_last);
        w_state_nxt = w_cyc_g ? GRANTED : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant capture, round-robin pointer and watchdog counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_grant <= '0;
      r_last  <= IDX_W'(NUM_MASTERS - 1);
      r_wdog  <= '0;
    end else begin
      if ((r_state == IDLE) && (w_state_nxt == GRANTED)) begin
        r_grant <= w_rr_gnt;
        r_last  <= w_rr_idx;
      end else if (w_state_nxt == IDLE) begin
        r_grant <= '0;
      end
      if (!WDOG_EN || !w_stall || (w_state_nxt != r_state)) r_wdog <= '0;
      else                                                   r_wdog <= r_wdog + CNT_W'(1);
    end
  end

  assign grant_o = r_grant;
  assign m_dat_o = s_dat_i;

endmodule
